// File: rtl/blink_rate_sel_pkg.sv
// Shared widths, types and the rate-to-interval helper for the LED blink rate selector.
package blink_pkg;

  localparam int INTERVAL_W = 24;
  localparam int RATE_IDX_W = 2;
  localparam int NUM_RATES  = 4;

  typedef logic [INTERVAL_W-1:0] interval_t;
  typedef logic [RATE_IDX_W-1:0] rate_idx_t;

  // Each rate step halves the toggle interval, i.e. doubles the blink frequency.
  function automatic interval_t rate_interval(input interval_t base, input rate_idx_t idx);
    return base >> idx;
  endfunction

endpackage

// File: rtl/blink_rate_sel_if.sv
// Button-in / rate-out bundle between the rate selector (master) and its environment (slave).
interface blink_rate_sel_if;
  import blink_pkg::*;

  logic      btn;
  interval_t interval;
  rate_idx_t rate_idx;
  logic      rate_changed;

  modport master (input btn, output interval, output rate_idx, output rate_changed);
  modport slave  (output btn, input interval, input rate_idx, input rate_changed);

endinterface

// File: rtl/blink_rate_sel_debounce.sv
// btn_debounce: 2-flop synchronizer plus consecutive-sample debouncer with a registered press strobe.
// press rises on the same edge that commits stable 0->1, so the top-level update lands at edge N+2+D.
module btn_debounce #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd250_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic stable,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 20'd1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 20'd1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;

  // Any sample that matches the accepted level restarts the run of differing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      s1    <= btn;
      s2    <= s1;
      press <= 1'b0;
      if (s2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= s2;
        cnt    <= '0;
        press  <= s2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/blink_rate_sel.sv
// blink_rate_sel: advances through four blink rates on each debounced press and drives the interval.
// Optional feature macro BLINK_LONG_PRESS_EN: holding the button LONG_PRESS_CYCLES returns to rate 0.
module blink_rate_sel
  import blink_pkg::*;
#(
  parameter interval_t   BASE_INTERVAL     = 24'd5_000_000,
  parameter logic [19:0] DEBOUNCE_CYCLES   = 20'd250_000,
  parameter interval_t   LONG_PRESS_CYCLES = 24'd10_000_000
) (
  input logic              clk,
  input logic              rst,
  blink_rate_sel_if.master bus
);

  logic      stable;
  logic      press;
  logic      hold_hit;
  rate_idx_t rate_idx_q;
  rate_idx_t next_idx;
  interval_t interval_q;
  logic      changed_q;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk    (clk),
    .rst    (rst),
    .btn    (bus.btn),
    .stable (stable),
    .press  (press)
  );

  assign next_idx = rate_idx_t'((int'(rate_idx_q) + 1) % NUM_RATES);

`ifdef BLINK_LONG_PRESS_EN
  interval_t hold_cnt;

  // Saturating at the threshold makes the reset fire exactly once per hold.
  always_ff @(posedge clk) begin
    if (rst || !stable) begin
      hold_cnt <= '0;
    end else if (hold_cnt != LONG_PRESS_CYCLES) begin
      hold_cnt <= hold_cnt + 24'd1;
    end
  end

  assign hold_hit = stable && (hold_cnt == LONG_PRESS_CYCLES - 24'd1);
`else
  logic unused_long_press;

  assign hold_hit          = 1'b0;
  assign unused_long_press = ^LONG_PRESS_CYCLES;
`endif

  // A long-press return to rate 0 takes precedence if it coincides with a press.
  always_ff @(posedge clk) begin
    if (rst) begin
      rate_idx_q <= '0;
      interval_q <= BASE_INTERVAL;
      changed_q  <= 1'b0;
    end else begin
      changed_q <= 1'b0;
      if (press) begin
        rate_idx_q <= next_idx;
        interval_q <= rate_interval(BASE_INTERVAL, next_idx);
        changed_q  <= 1'b1;
      end
      if (hold_hit) begin
        rate_idx_q <= '0;
        interval_q <= BASE_INTERVAL;
        changed_q  <= 1'b1;
      end
    end
  end

  assign bus.interval     = interval_q;
  assign bus.rate_idx     = rate_idx_q;
  assign bus.rate_changed = changed_q;

endmodule

// File: tb/tb_blink_rate_sel.sv
// Bench for blink_rate_sel: fixed vector table, hand-built corner sequences and randomized button
// activity checked against a sample-window reference model (honours BLINK_LONG_PRESS_EN).
module tb_blink_rate_sel;
  import blink_pkg::*;

  localparam interval_t   BASE  = 24'd1000;
  localparam logic [19:0] DEB   = 20'd4;
  localparam interval_t   LONGP = 24'd20;
  localparam int          D     = 4;
  localparam int          LP    = 20;
`ifdef BLINK_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  blink_rate_sel_if bus();

  blink_rate_sel #(
    .BASE_INTERVAL     (BASE),
    .DEBOUNCE_CYCLES   (DEB),
    .LONG_PRESS_CYCLES (LONGP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int pulseCount  = 0;

  // Reference model: the accepted level flips once the last D synchronized samples all disagree.
  bit btnHist[$];
  bit s2Hist[$];
  bit mStable;
  bit mPressPending;
  bit mChanged;
  int mIdx;
  int mInterval;
  int mHold;

  function automatic void modelReset();
    btnHist.delete();
    s2Hist.delete();
    mStable       = 1'b0;
    mPressPending = 1'b0;
    mChanged      = 1'b0;
    mIdx          = 0;
    mInterval     = int'(BASE);
    mHold         = 0;
  endfunction

  function automatic void modelStep(bit b);
    bit s2;
    bit commit;
    mChanged = 1'b0;
    if (mPressPending) begin
      mIdx      = (mIdx + 1) % 4;
      mInterval = int'(BASE) / (1 << mIdx);
      mChanged  = 1'b1;
    end
    mPressPending = 1'b0;
    if (mStable) begin
      if (mHold < LP) begin
        mHold++;
        if (mHold == LP && LONG_EN) begin
          mIdx      = 0;
          mInterval = int'(BASE);
          mChanged  = 1'b1;
        end
      end
    end else begin
      mHold = 0;
    end
    s2 = (btnHist.size() >= 2) ? btnHist[btnHist.size()-2] : 1'b0;
    btnHist.push_back(b);
    if (btnHist.size() > 2) void'(btnHist.pop_front());
    s2Hist.push_back(s2);
    if (s2Hist.size() > D) void'(s2Hist.pop_front());
    commit = (s2Hist.size() == D);
    foreach (s2Hist[i]) if (s2Hist[i] == mStable) commit = 1'b0;
    if (commit) begin
      mStable       = ~mStable;
      mPressPending = mStable;
      s2Hist.delete();
    end
  endfunction

  task automatic checkOutput();
    vectors++;
    if (bus.rate_changed === 1'b1) pulseCount++;
    if (bus.interval !== interval_t'(mInterval) || bus.rate_idx !== rate_idx_t'(mIdx) ||
        bus.rate_changed !== mChanged) begin
      miscompares++;
      $display("[TB] FAIL model @%0t: got interval=%0d idx=%0d changed=%0b, want interval=%0d idx=%0d changed=%0b",
               $time, bus.interval, bus.rate_idx, bus.rate_changed, mInterval, mIdx, mChanged);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit b);
    rst     = r;
    bus.btn = b;
    @(posedge clk);
    if (r) modelReset();
    else   modelStep(b);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic checkExpect(input string name, input int expInt, input int expIdx, input bit expCh);
    vectors++;
    if (bus.interval !== interval_t'(expInt) || bus.rate_idx !== rate_idx_t'(expIdx) ||
        bus.rate_changed !== expCh) begin
      miscompares++;
      $display("[TB] FAIL %s: got interval=%0d idx=%0d changed=%0b, want interval=%0d idx=%0d changed=%0b",
               name, bus.interval, bus.rate_idx, bus.rate_changed, expInt, expIdx, expCh);
    end
  endtask

  task automatic checkCount(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic pressOnce(input int highCycles, input int lowCycles);
    for (int i = 0; i < highCycles; i++) applyStimulus(1'b0, 1'b1);
    for (int i = 0; i < lowCycles; i++)  applyStimulus(1'b0, 1'b0);
  endtask

  typedef struct {
    bit rst;
    bit btn;
    int expInterval;
    int expIdx;
    bit expChanged;
  } vec_t;

  vec_t tbl[20];

  initial begin
    int wrapInt[4] = '{500, 250, 125, 1000};
    int wrapIdx[4] = '{1, 2, 3, 0};
    bit level;
    int runLen;

    // Reset for 2 cycles, btn high at entry 2 for 10 cycles: update visible after edge 2+2+D.
    for (int i = 0; i < 20; i++) begin
      tbl[i].rst         = (i < 2);
      tbl[i].btn         = (i >= 2 && i < 12);
      tbl[i].expInterval = (i >= 8) ? 500 : 1000;
      tbl[i].expIdx      = (i >= 8) ? 1 : 0;
      tbl[i].expChanged  = (i == 8);
    end

    modelReset();
    for (int i = 0; i < 20; i++) begin
      applyStimulus(tbl[i].rst, tbl[i].btn);
      checkExpect($sformatf("table[%0d]", i), tbl[i].expInterval, tbl[i].expIdx, tbl[i].expChanged);
    end

    // Bounce 1,0,1,1,0,1 then hold: one update only.
    pulseCount = 0;
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0);
    pressOnce(13, 8);
    checkCount("bounce pulses", pulseCount, 1);
    checkExpect("bounce final", 250, 2, 1'b0);

    // Wrap through all four rates from reset.
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    for (int p = 0; p < 4; p++) begin
      pressOnce(8, 8);
      checkExpect($sformatf("wrap[%0d]", p), wrapInt[p], wrapIdx[p], 1'b0);
    end

    // Reset mid-debounce with the button still held afterwards.
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1);
    checkExpect("mid-debounce reset", 1000, 0, 1'b0);
    pulseCount = 0;
    pressOnce(10, 8);
    checkCount("post-reset pulses", pulseCount, 1);
    checkExpect("post-reset final", 500, 1, 1'b0);

    // Long hold from rate 2.
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    pressOnce(8, 8);
    pressOnce(8, 8);
    pulseCount = 0;
    pressOnce(40, 10);
    checkCount("long hold pulses", pulseCount, LONG_EN ? 2 : 1);
    checkExpect("long hold final", LONG_EN ? 1000 : 125, LONG_EN ? 0 : 3, 1'b0);

    // Random button runs with occasional resets.
    level = 1'b0;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        applyStimulus(1'b1, level);
      end
      level  = ~level;
      runLen = $urandom_range(1, 8);
      for (int k = 0; k < runLen; k++) applyStimulus(1'b0, level);
    end
    pressOnce(0, 10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
